// File: rtl/sram_like_to_axi_pkg.sv
// sram_like_to_axi_pkg: FSM encoding, AXI constants and write-strobe helpers for the sram-like to AXI responder.
package sram_like_to_axi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_AR,
        RD_R,
        WR_REQ,
        WR_B
    } state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_WORD  = 3'b010;

    function automatic logic [3:0] wstrb_enc(input logic [1:0] size, input logic [1:0] a);
        return size == 2'd0 ? 4'b0001 << a : size == 2'd1 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

    // sram-like size 3 is an alias for a word access
    function automatic logic [2:0] axsize_enc(input logic [1:0] size);
        return size == 2'd3 ? SIZE_WORD : {1'b0, size};
    endfunction

endpackage

// File: rtl/sram_like_to_axi.sv
// sram_like_to_axi: executes one sram-like request at a time as a single-beat AXI3 transaction.
module sram_like_to_axi
    import sram_like_to_axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata_axi,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata_axi,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    state_e      state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        unused_resp;

    assign unused_resp = ^{rid, rresp, rlast, bid, bresp};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            size_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        addr_ok   = 1'b0;
        data_ok   = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        case (state_q)
            IDLE: begin
                addr_ok = req & ~rst;
                if (req) begin
                    size_d  = size;
                    addr_d  = addr;
                    wdata_d = wdata;
                    state_d = wr ? WR_REQ : RD_AR;
                end
            end
            RD_AR: begin
                arvalid = 1'b1;
                state_d = arready ? RD_R : RD_AR;
            end
            RD_R: begin
                rready  = 1'b1;
                data_ok = rvalid;
                state_d = rvalid ? IDLE : RD_R;
            end
            WR_REQ: begin
                // AW and W complete independently; leave only once both have handshaken
                awvalid   = ~aw_done_q;
                wvalid    = ~w_done_q;
                aw_done_d = aw_done_q | awready;
                w_done_d  = w_done_q | wready;
                if (aw_done_d && w_done_d) begin
                    state_d   = WR_B;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            WR_B: begin
                bready  = 1'b1;
                data_ok = bvalid;
                state_d = bvalid ? IDLE : WR_B;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rdata     = rdata_axi;
    assign arid      = AXI_ID;
    assign araddr    = addr_q;
    assign arlen     = 8'd0;
    assign arsize    = axsize_enc(size_q);
    assign arburst   = BURST_INCR;
    assign arlock    = 2'd0;
    assign arcache   = 4'd0;
    assign arprot    = 3'd0;
    assign awid      = AXI_ID;
    assign awaddr    = addr_q;
    assign awlen     = 8'd0;
    assign awsize    = axsize_enc(size_q);
    assign awburst   = BURST_INCR;
    assign awlock    = 2'd0;
    assign awcache   = 4'd0;
    assign awprot    = 3'd0;
    assign wid       = AXI_ID;
    assign wdata_axi = wdata_q;
    assign wstrb     = wstrb_enc(size_q, addr_q[1:0]);
    assign wlast     = 1'b1;

endmodule
